// File: rtl/sobel_mem_responder_pkg.sv
// rtl/sobel_mem_responder_pkg.sv - shared constants and read FSM state type
package sobel_pkg;

    localparam int PIX_DEPTH  = 4096;
    localparam int RES_DEPTH  = 2048;
    localparam int WIN_PIXELS = 9;
    localparam int PIX_AW     = 12;
    localparam int RES_AW     = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ACK   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sobel_mem_responder_if.sv
// rtl/sobel_mem_responder_if.sv - window read / result write request bus
interface sobel_mem_responder_if;

    logic        mem_read_req;
    logic [31:0] mem_read_addr;
    logic        mem_read_ack;
    logic [71:0] mem_read_data;
    logic        mem_write_req;
    logic [31:0] mem_write_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_ack;

    modport master (
        output mem_read_req, mem_read_addr, mem_write_req, mem_write_addr, mem_write_data,
        input  mem_read_ack, mem_read_data, mem_write_ack
    );

    modport slave (
        input  mem_read_req, mem_read_addr, mem_write_req, mem_write_addr, mem_write_data,
        output mem_read_ack, mem_read_data, mem_write_ack
    );

endinterface

// File: rtl/sobel_mem_responder_pixel_ram.sv
// rtl/sobel_mem_responder_pixel_ram.sv - 4096x8 single-port pixel RAM, synchronous read
module sobel_pixel_ram
    import sobel_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [PIX_AW-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [PIX_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/sobel_mem_responder.sv
// rtl/sobel_mem_responder.sv - serves 3x3 pixel windows and stores 16-bit gradient results
module sobel_mem_responder
    import sobel_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] img_width,
    input  logic [31:0] src_base,
    input  logic [31:0] dst_base,
    sobel_mem_responder_if.slave mem,
    input  logic        load_we,
    input  logic [11:0] load_addr,
    input  logic [7:0]  load_data,
    input  logic [10:0] res_addr,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        err_read_oob,
    output logic        err_write_oob,
    output logic        err_load,
    input  logic        err_clr,
    output logic [15:0] read_count,
    output logic [15:0] write_count
);

    localparam logic [3:0] LAST_TAP = 4'(WIN_PIXELS - 1);

    rd_state_e   state_q, state_d;
    logic [3:0]  cnt_q;
    logic [1:0]  col_q;
    logic [11:0] row_q;
    logic [63:0] win_q;
    logic        oob_q;
    logic        rd_ack_q, wr_ack_q;
    logic [71:0] rd_data_q;
    logic [15:0] rd_cnt_q, wr_cnt_q, res_data_q;
    logic        err_rd_q, err_wr_q, err_ld_q;

    logic [31:0] rd_off, rd_span, wr_off, wr_idx;
    logic        rd_oob, rd_accept, wr_oob, wr_accept;
    logic        pix_we;
    logic [11:0] pix_addr;
    logic [7:0]  pix_rdata;
    logic [15:0] res_mem_q [RES_DEPTH];

    // Bounds are checked on the far corner of the window at full 32-bit width.
    assign rd_off    = mem.mem_read_addr - src_base;
    assign rd_span   = rd_off + {15'd0, img_width, 1'b0} + 32'd2;
    assign rd_oob    = (mem.mem_read_addr < src_base) || (rd_span > 32'(PIX_DEPTH - 1));
    assign rd_accept = (state_q == ST_IDLE) && mem.mem_read_req;

    assign wr_off    = mem.mem_write_addr - dst_base;
    assign wr_idx    = wr_off >> 1;
    assign wr_oob    = (mem.mem_write_addr < dst_base) || mem.mem_write_addr[0]
                       || (wr_idx > 32'(RES_DEPTH - 1));
    assign wr_accept = mem.mem_write_req && !wr_ack_q;

    assign pix_we   = load_we && (state_q == ST_IDLE);
    assign pix_addr = (state_q == ST_FETCH) ? (row_q + {10'd0, col_q}) : load_addr;

    sobel_pixel_ram u_pixel_ram (
        .clk     (clk),
        .we_i    (pix_we),
        .addr_i  (pix_addr),
        .wdata_i (load_data),
        .rdata_o (pix_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (mem.mem_read_req) state_d = rd_oob ? ST_ACK : ST_FETCH;
            ST_FETCH: if (cnt_q == LAST_TAP) state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // RAM data lags the issued index by one cycle, so tap k is shifted in while cnt_q == k+1
    // and the ninth tap is taken straight from the RAM output in ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            oob_q     <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rd_accept) begin
                        oob_q <= rd_oob;
                        row_q <= rd_off[11:0];
                        col_q <= '0;
                        cnt_q <= '0;
                    end
                end
                ST_FETCH: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (col_q == 2'd2) begin
                        col_q <= '0;
                        row_q <= row_q + img_width[11:0];
                    end else begin
                        col_q <= col_q + 2'd1;
                    end
                    if (cnt_q != 4'd0) begin
                        win_q <= {win_q[55:0], pix_rdata};
                    end
                end
                ST_ACK: begin
                    rd_ack_q  <= 1'b1;
                    rd_data_q <= oob_q ? 72'd0 : {win_q, pix_rdata};
                    rd_cnt_q  <= rd_cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack_q <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            wr_ack_q <= wr_accept;
            if (wr_accept) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !wr_oob) begin
            res_mem_q[wr_idx[RES_AW-1:0]] <= mem.mem_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q <= '0;
        end else begin
            res_data_q <= res_mem_q[res_addr];
        end
    end

    // Clear is applied first so a same-cycle error event overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_rd_q <= 1'b0;
            err_wr_q <= 1'b0;
            err_ld_q <= 1'b0;
        end else begin
            if (err_clr) begin
                err_rd_q <= 1'b0;
                err_wr_q <= 1'b0;
                err_ld_q <= 1'b0;
            end
            if (rd_accept && rd_oob) err_rd_q <= 1'b1;
            if (wr_accept && wr_oob) err_wr_q <= 1'b1;
            if (load_we && (state_q != ST_IDLE)) err_ld_q <= 1'b1;
        end
    end

    assign mem.mem_read_ack  = rd_ack_q;
    assign mem.mem_read_data = rd_data_q;
    assign mem.mem_write_ack = wr_ack_q;
    assign res_data      = res_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_read_oob  = err_rd_q;
    assign err_write_oob = err_wr_q;
    assign err_load      = err_ld_q;
    assign read_count    = rd_cnt_q;
    assign write_count   = wr_cnt_q;

endmodule

// File: tb/tb_sobel_mem_responder.sv
// tb/tb_sobel_mem_responder.sv - directed self-checking bench for sobel_mem_responder
module tb_sobel_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] img_width = 16'd32;
    logic [31:0] src_base = 32'h1000;
    logic [31:0] dst_base = 32'h2000;
    logic        load_we = 1'b0;
    logic [11:0] load_addr = '0;
    logic [7:0]  load_data = '0;
    logic [10:0] res_addr = '0;
    logic [15:0] res_data;
    logic        busy, err_read_oob, err_write_oob, err_load;
    logic        err_clr = 1'b0;
    logic [15:0] read_count, write_count;

    sobel_mem_responder_if mif ();

    sobel_mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .img_width     (img_width),
        .src_base      (src_base),
        .dst_base      (dst_base),
        .mem           (mif),
        .load_we       (load_we),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .res_addr      (res_addr),
        .res_data      (res_data),
        .busy          (busy),
        .err_read_oob  (err_read_oob),
        .err_write_oob (err_write_oob),
        .err_load      (err_load),
        .err_clr       (err_clr),
        .read_count    (read_count),
        .write_count   (write_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic rst_edge = 1'b1;

    logic [7:0]  m_pix [4096];
    logic [15:0] m_res [2048];
    logic [15:0] m_rcount = '0, m_wcount = '0;
    logic [71:0] m_hold = '0, rd_exp = '0;
    int rd_due = -1, wr_due = -1, rd_raise = 0, wr_raise = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window as the spec defines it: rows of img_width, 3x3 taps, zero when out of range.
    function automatic logic [71:0] model_window(input logic [31:0] addr);
        logic [31:0] off;
        logic [71:0] w;
        off = addr - src_base;
        if (addr < src_base || off + 32'(img_width) * 2 + 2 > 32'd4095) return 72'd0;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w = {w[63:0], m_pix[int'(off) + r * int'(img_width) + c]};
        return w;
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_edge = rst;
    end

    always @(negedge clk) begin
        if (rst_edge) begin
            m_rcount = '0;
            m_wcount = '0;
            m_hold   = '0;
            rd_due   = -1;
            wr_due   = -1;
        end else begin
            if (cyc == rd_due) begin
                m_rcount++;
                m_hold = rd_exp;
            end
            if (cyc == wr_due) m_wcount++;
        end
        check("read_ack", mif.mem_read_ack, (!rst_edge && cyc == rd_due));
        check("read_data", mif.mem_read_data, m_hold);
        check("write_ack", mif.mem_write_ack, (!rst_edge && cyc == wr_due));
        check("read_count", read_count, m_rcount);
        check("write_count", write_count, m_wcount);
    end

    task automatic start_read(input logic [31:0] addr);
        logic [31:0] off;
        logic oob;
        @(negedge clk);
        off = addr - src_base;
        oob = (addr < src_base) || (off + 32'(img_width) * 2 + 2 > 32'd4095);
        rd_exp   = model_window(addr);
        rd_raise = cyc;
        rd_due   = cyc + (oob ? 2 : 11);
        mif.mem_read_addr = addr;
        mif.mem_read_req  = 1'b1;
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [15:0] data, input logic same_cycle);
        logic [31:0] off;
        if (!same_cycle) @(negedge clk);
        off = addr - dst_base;
        if (!(addr < dst_base || addr[0] || (off >> 1) > 32'd2047)) m_res[off >> 1] = data;
        wr_raise = cyc;
        wr_due   = cyc + 1;
        mif.mem_write_addr = addr;
        mif.mem_write_data = data;
        mif.mem_write_req  = 1'b1;
    endtask

    task automatic wait_read(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.mem_read_ack) begin
                lat = cyc - rd_raise;
                break;
            end
        end
        mif.mem_read_req = 1'b0;
        if (lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL read_timeout: got no ack expected ack within 40 cycles");
        end
    endtask

    task automatic wait_write(output int lat);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mif.mem_write_ack) begin
                lat = cyc - wr_raise;
                break;
            end
        end
        mif.mem_write_req = 1'b0;
        if (lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL write_timeout: got no ack expected ack within 10 cycles");
        end
    endtask

    task automatic readback(input logic [10:0] idx, input logic [15:0] lit, input string name);
        @(negedge clk);
        res_addr = idx;
        @(negedge clk);
        check(name, res_data, m_res[idx]);
        check({name, "_lit"}, res_data, lit);
    endtask

    int lat;

    initial begin
        mif.mem_read_req   = 1'b0;
        mif.mem_read_addr  = '0;
        mif.mem_write_req  = 1'b0;
        mif.mem_write_addr = '0;
        mif.mem_write_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_rdata", mif.mem_read_data, 0);
        check("rst_res_data", res_data, 0);
        check("rst_errs", {err_read_oob, err_write_oob, err_load}, 0);
        check("rst_counts", {read_count, write_count}, 0);

        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            load_we = 1'b1;
            load_addr = 12'(i);
            load_data = 8'(i);
            m_pix[i] = 8'(i);
        end
        @(negedge clk);
        load_we = 1'b0;

        start_read(32'h1000);
        check("model_win_1000", model_window(32'h1000), 72'h000102_202122_404142);
        wait_read(lat);
        check("read_latency", lat, 11);
        check("read_1000_data", mif.mem_read_data, 72'h000102_202122_404142);

        start_write(32'h2002, 16'd123, 1'b0);
        wait_write(lat);
        check("write_latency", lat, 1);
        check("write_count_lit", write_count, 1);
        readback(11'd1, 16'd123, "res_idx1");

        start_read(32'h1021);
        start_write(32'h2000, 16'h0BEE, 1'b1);
        check("model_win_1021", rd_exp, 72'h212223_414243_616263);
        wait_write(lat);
        check("both_write_latency", lat, 1);
        wait_read(lat);
        check("both_read_latency", lat, 11);
        check("read_1021_data", mif.mem_read_data, 72'h212223_414243_616263);
        readback(11'd0, 16'h0BEE, "res_idx0");

        start_read(32'h0FFF);
        wait_read(lat);
        check("oob_read_latency", lat, 2);
        check("oob_read_data", mif.mem_read_data, 0);
        check("err_read_oob", err_read_oob, 1);
        start_write(32'h2001, 16'hDEAD, 1'b0);
        wait_write(lat);
        check("err_write_oob", err_write_oob, 1);
        readback(11'd0, 16'h0BEE, "res_idx0_kept");
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", {err_read_oob, err_write_oob}, 0);

        start_read(32'h1000);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        mif.mem_read_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_counts", {read_count, write_count}, 0);
        repeat (15) @(negedge clk);
        start_read(32'h1000);
        wait_read(lat);
        check("post_rst_data", mif.mem_read_data, 72'h000102_202122_404142);

        start_read(32'h1000);
        repeat (3) @(negedge clk);
        load_we = 1'b1;
        load_addr = 12'd5;
        load_data = 8'hAA;
        @(negedge clk);
        load_we = 1'b0;
        wait_read(lat);
        check("err_load", err_load, 1);
        start_read(32'h1004);
        wait_read(lat);
        check("pix5_kept", mif.mem_read_data[63:56], 8'h05);
        check("read_1004_data", mif.mem_read_data, 72'h040506_242526_444546);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
